// File: rtl/mem_port_arbiter_pkg.sv
// mips_mem_pkg: shared types for the pipe_MIPS32 memory-port arbiter.
//   AW_DEF/DW_DEF  default word-address and data widths
//   state_t        arbiter FSM states (IDLE, WAIT, ACK)
//   owner_t        which requester owns the transaction in flight
//   pick_t         one-hot winner produced by arb_pick
package mips_mem_pkg;

    localparam int AW_DEF = 10;
    localparam int DW_DEF = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_LD   = 2'd1,
        OWN_DS   = 2'd2,
        OWN_IF   = 2'd3
    } owner_t;

    // One-hot winner: loader, load/store unit, fetch unit.
    typedef struct packed {
        logic ld;
        logic ds;
        logic fe;
    } pick_t;

    function automatic owner_t pick_to_owner(input pick_t p);
        if (p.ld) return OWN_LD;
        if (p.ds) return OWN_DS;
        if (p.fe) return OWN_IF;
        return OWN_NONE;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester handshakes (ld/ds/if) plus the memory bus.
//   slave  modport: the arbiter (takes requests, drives gnt/ack/rdata and mem_*)
//   master modport: the environment (requesters and the memory itself)
interface mem_port_arbiter_if
    import mips_mem_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
);

    // program loader
    logic          ld_req;
    logic          ld_we;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_wdata;
    logic          ld_gnt;
    logic          ld_ack;

    // MEM-stage load/store unit
    logic          ds_req;
    logic          ds_we;
    logic [AW-1:0] ds_addr;
    logic [DW-1:0] ds_wdata;
    logic          ds_gnt;
    logic          ds_ack;
    logic [DW-1:0] ds_rdata;

    // IF-stage fetch unit
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_ack;
    logic [DW-1:0] if_rdata;

    // single-ported memory
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  ld_req, ld_we, ld_addr, ld_wdata,
        output ld_gnt, ld_ack,
        input  ds_req, ds_we, ds_addr, ds_wdata,
        output ds_gnt, ds_ack, ds_rdata,
        input  if_req, if_addr,
        output if_gnt, if_ack, if_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output ld_req, ld_we, ld_addr, ld_wdata,
        input  ld_gnt, ld_ack,
        output ds_req, ds_we, ds_addr, ds_wdata,
        input  ds_gnt, ds_ack, ds_rdata,
        output if_req, if_addr,
        input  if_gnt, if_ack, if_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/mem_port_arbiter_arb_pick.sv
// arb_pick: combinational fixed-priority picker, ld > ds > if.
// When the fetch unit has been starved it is promoted above ds (never above ld).
// A halted pipeline masks the fetch request entirely.
//   ld_req, ds_req, if_req  raw requests
//   halted                  pipeline HALTED flag
//   starved                 fetch has lost STARVE_MAX arbitrations in a row
//   win                     one-hot winner, all zero when nobody requests
module arb_pick
    import mips_mem_pkg::*;
(
    input  logic  ld_req,
    input  logic  ds_req,
    input  logic  if_req,
    input  logic  halted,
    input  logic  starved,
    output pick_t win
);

    logic fetch_ok;

    assign fetch_ok = if_req & ~halted;

    always_comb begin
        // NOTE: default every output first so no path leaves it unassigned (no latch).
        win = '0;
        if (ld_req) begin
            win.ld = 1'b1;
        end else if (fetch_ok && (starved || !ds_req)) begin
            win.fe = 1'b1;
        end else if (ds_req) begin
            win.ds = 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single-ported unified memory of pipe_MIPS32
// between the program loader, the MEM-stage load/store unit and the IF fetch.
// One transaction is outstanding at a time:
//   IDLE  arbitrate; the winner's gnt and mem_en are registered for the next cycle
//   WAIT  hold address/data while the memory latency elapses
//   ACK   memory data is valid; capture it and register the owner's ack
// The ack and captured rdata therefore appear in the cycle after ACK, i.e.
// MEM_LAT+1 cycles after the grant, while a new arbitration already runs.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   bus          requester handshakes and memory bus (slave modport)
//   halted       pipeline HALTED flag; blocks fetch grants
//   busy         transaction in flight (WAIT or ACK)
//   hold_pipe    combinational stall request to the pipeline
module mem_port_arbiter
    import mips_mem_pkg::*;
#(
    parameter int AW         = AW_DEF,
    parameter int DW         = DW_DEF,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_port_arbiter_if.slave bus,
    input  logic              halted,
    output logic              busy,
    output logic              hold_pipe
);

    localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int STV_W = $clog2(STARVE_MAX + 1);

    state_t           state;
    owner_t           owner;
    logic [LAT_W-1:0] lat_cnt;
    logic [STV_W-1:0] starve_cnt;
    logic             acc_we;      // write flag of the access in flight

    pick_t            win;
    logic             any_win;
    logic             fetch_ok;
    logic             starved;

    logic             sel_we;
    logic [AW-1:0]    sel_addr;
    logic [DW-1:0]    sel_wdata;

    assign fetch_ok = bus.if_req & ~halted;
    assign starved  = (starve_cnt == STV_W'(STARVE_MAX));
    assign any_win  = win.ld | win.ds | win.fe;

    arb_pick u_pick (
        .ld_req  (bus.ld_req),
        .ds_req  (bus.ds_req),
        .if_req  (bus.if_req),
        .halted  (halted),
        .starved (starved),
        .win     (win)
    );

    // Request fields of whichever requester wins this cycle.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        if (win.ld) begin
            sel_we    = bus.ld_we;
            sel_addr  = bus.ld_addr;
            sel_wdata = bus.ld_wdata;
        end else if (win.ds) begin
            sel_we    = bus.ds_we;
            sel_addr  = bus.ds_addr;
            sel_wdata = bus.ds_wdata;
        end else if (win.fe) begin
            sel_addr  = bus.if_addr;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            owner         <= OWN_NONE;
            lat_cnt       <= '0;
            starve_cnt    <= '0;
            acc_we        <= 1'b0;
            bus.ld_gnt    <= 1'b0;
            bus.ld_ack    <= 1'b0;
            bus.ds_gnt    <= 1'b0;
            bus.ds_ack    <= 1'b0;
            bus.if_gnt    <= 1'b0;
            bus.if_ack    <= 1'b0;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            // NOTE: the rdata holding registers are plain flops, so they are reset
            // like everything else; a reset clears the last returned word.
            bus.ds_rdata  <= '0;
            bus.if_rdata  <= '0;
        end else begin
            // Handshake strobes are single-cycle pulses by default.
            bus.ld_gnt <= 1'b0;
            bus.ds_gnt <= 1'b0;
            bus.if_gnt <= 1'b0;
            bus.ld_ack <= 1'b0;
            bus.ds_ack <= 1'b0;
            bus.if_ack <= 1'b0;
            bus.mem_en <= 1'b0;
            bus.mem_we <= 1'b0;

            case (state)
                IDLE: begin
                    if (any_win) begin
                        bus.ld_gnt    <= win.ld;
                        bus.ds_gnt    <= win.ds;
                        bus.if_gnt    <= win.fe;
                        bus.mem_en    <= 1'b1;
                        bus.mem_we    <= sel_we;
                        bus.mem_addr  <= sel_addr;
                        bus.mem_wdata <= sel_wdata;
                        acc_we        <= sel_we;
                        owner         <= pick_to_owner(win);
                        lat_cnt       <= LAT_W'(MEM_LAT - 1);
                        state         <= WAIT;
                        // Fetch lost an arbitration it was eligible for: count it.
                        if (win.fe) begin
                            starve_cnt <= '0;
                        end else if (fetch_ok && !starved) begin
                            starve_cnt <= starve_cnt + STV_W'(1);
                        end
                    end
                end

                WAIT: begin
                    if (lat_cnt == '0) begin
                        state <= ACK;
                    end else begin
                        lat_cnt <= lat_cnt - LAT_W'(1);
                    end
                end

                ACK: begin
                    case (owner)
                        OWN_LD: bus.ld_ack <= 1'b1;
                        OWN_DS: begin
                            bus.ds_ack <= 1'b1;
                            if (!acc_we) begin
                                bus.ds_rdata <= bus.mem_rdata;
                            end
                        end
                        OWN_IF: begin
                            bus.if_ack   <= 1'b1;
                            bus.if_rdata <= bus.mem_rdata;
                        end
                        default: ;
                    endcase
                    owner <= OWN_NONE;
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign hold_pipe = bus.ds_req | fetch_ok |
                       (busy & ((owner == OWN_DS) | (owner == OWN_IF)));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a MEM_LAT=1 instance (dut_a) carries
// most scenarios, a MEM_LAT=3 instance (dut_b) covers the longer latency.
module tb_mem_port_arbiter;
    import mips_mem_pkg::*;

    localparam int AW = 10;
    localparam int DW = 32;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic halted = 1'b0;
    logic busy_a, hold_a, busy_b, hold_b;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus_a ();
    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus_b ();

    mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(1), .STARVE_MAX(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a), .halted(halted),
        .busy(busy_a), .hold_pipe(hold_a)
    );

    mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(3), .STARVE_MAX(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b), .halted(1'b0),
        .busy(busy_b), .hold_pipe(hold_b)
    );

    // Memory A: synchronous RAM, read data one cycle after mem_en.
    logic [DW-1:0] mem_a [1024];
    logic [DW-1:0] rd_a;
    always @(posedge clk) begin
        if (bus_a.mem_en) begin
            if (bus_a.mem_we) mem_a[bus_a.mem_addr] <= bus_a.mem_wdata;
            else              rd_a <= mem_a[bus_a.mem_addr];
        end
    end
    assign bus_a.mem_rdata = rd_a;

    // Memory B: read data three cycles after mem_en.
    logic [DW-1:0] mem_b [1024];
    logic [DW-1:0] p1, p2, p3;
    always @(posedge clk) begin
        if (bus_b.mem_en) begin
            if (bus_b.mem_we) mem_b[bus_b.mem_addr] <= bus_b.mem_wdata;
            else              p1 <= mem_b[bus_b.mem_addr];
        end
        p2 <= p1;
        p3 <= p2;
    end
    assign bus_b.mem_rdata = p3;

    // Event log for dut_a, cycle numbers relative to start().
    int      cyc;
    int      gnt_at [4];
    int      ack_at [4];
    owner_t  seq [16];
    int      n_gnt;
    int      memwe_cnt;
    logic    sticky;
    logic [DW-1:0] ds_seen, if_seen;

    task automatic start();
        cyc = 0;
        foreach (gnt_at[i]) begin
            gnt_at[i] = -1;
            ack_at[i] = -1;
        end
        foreach (seq[i]) seq[i] = OWN_NONE;
        n_gnt     = 0;
        memwe_cnt = 0;
        ds_seen   = '0;
        if_seen   = '0;
    endtask

    task automatic log_gnt(input owner_t o);
        gnt_at[o] = cyc;
        if (n_gnt < 16) seq[n_gnt] = o;
        n_gnt++;
    endtask

    // Advance one cycle, sample #1 after the edge, drop requests once granted.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (bus_a.ld_gnt) begin log_gnt(OWN_LD); if (!sticky) bus_a.ld_req = 1'b0; end
        if (bus_a.ds_gnt) begin log_gnt(OWN_DS); if (!sticky) bus_a.ds_req = 1'b0; end
        if (bus_a.if_gnt) begin log_gnt(OWN_IF); if (!sticky) bus_a.if_req = 1'b0; end
        if (bus_a.ld_ack) ack_at[OWN_LD] = cyc;
        if (bus_a.ds_ack) begin ack_at[OWN_DS] = cyc; ds_seen = bus_a.ds_rdata; end
        if (bus_a.if_ack) begin ack_at[OWN_IF] = cyc; if_seen = bus_a.if_rdata; end
        if (bus_a.mem_we) memwe_cnt++;
    endtask

    task automatic test_reset();
        #1;
        nvec++;
        if ({bus_a.ld_gnt, bus_a.ds_gnt, bus_a.if_gnt, bus_a.ld_ack, bus_a.ds_ack, bus_a.if_ack} !== 6'b0) begin
            nerr++; $display("FAIL reset_handshake: got %b want 000000",
                {bus_a.ld_gnt, bus_a.ds_gnt, bus_a.if_gnt, bus_a.ld_ack, bus_a.ds_ack, bus_a.if_ack});
        end
        nvec++;
        if ({bus_a.mem_en, bus_a.mem_we, bus_a.mem_addr, bus_a.mem_wdata} !== '0) begin
            nerr++; $display("FAIL reset_membus: got en=%b we=%b addr=%h wdata=%h want all 0",
                bus_a.mem_en, bus_a.mem_we, bus_a.mem_addr, bus_a.mem_wdata);
        end
        nvec++;
        if ({bus_a.ds_rdata, bus_a.if_rdata} !== 64'h0) begin
            nerr++; $display("FAIL reset_rdata: got ds=%h if=%h want 0", bus_a.ds_rdata, bus_a.if_rdata);
        end
        nvec++;
        if ({busy_a, hold_a, busy_b, hold_b} !== 4'b0) begin
            nerr++; $display("FAIL reset_busy_hold: got %b want 0000", {busy_a, hold_a, busy_b, hold_b});
        end
        #10 rst_n = 1'b1;
    endtask

    // Loader preloads Mem[0] through the arbiter.
    task automatic test_loader();
        start();
        bus_a.ld_req = 1'b1; bus_a.ld_we = 1'b1;
        bus_a.ld_addr = 10'd0; bus_a.ld_wdata = 32'h2801000a;
        tick();
        nvec++;
        if ({bus_a.ld_gnt, bus_a.mem_en, bus_a.mem_we, busy_a, hold_a} !== 5'b11110) begin
            nerr++; $display("FAIL ld_grant: got gnt/en/we/busy/hold=%b want 11110",
                {bus_a.ld_gnt, bus_a.mem_en, bus_a.mem_we, busy_a, hold_a});
        end
        nvec++;
        if ({bus_a.mem_addr, bus_a.mem_wdata} !== {10'd0, 32'h2801000a}) begin
            nerr++; $display("FAIL ld_membus: got addr=%h wdata=%h want 000 2801000a",
                bus_a.mem_addr, bus_a.mem_wdata);
        end
        tick();
        nvec++;
        if ({bus_a.ld_gnt, bus_a.mem_en, bus_a.mem_we} !== 3'b000) begin
            nerr++; $display("FAIL ld_wait_strobes: got %b want 000", {bus_a.ld_gnt, bus_a.mem_en, bus_a.mem_we});
        end
        tick();
        tick();
        nvec++;
        if (ack_at[OWN_LD] !== 3) begin
            nerr++; $display("FAIL ld_ack_cycle: got %0d want 3", ack_at[OWN_LD]);
        end
        bus_a.ld_we = 1'b0;
    endtask

    task automatic test_single_fetch();
        start();
        bus_a.if_req = 1'b1; bus_a.if_addr = 10'd0;
        #1;
        nvec++;
        if (hold_a !== 1'b1) begin
            nerr++; $display("FAIL fetch_hold_req: got %b want 1", hold_a);
        end
        tick();
        nvec++;
        if ({bus_a.if_gnt, bus_a.mem_en, bus_a.mem_we, bus_a.mem_addr} !== {3'b110, 10'd0}) begin
            nerr++; $display("FAIL fetch_grant: got gnt=%b en=%b we=%b addr=%h want 1 1 0 000",
                bus_a.if_gnt, bus_a.mem_en, bus_a.mem_we, bus_a.mem_addr);
        end
        nvec++;
        if (hold_a !== 1'b1) begin
            nerr++; $display("FAIL fetch_hold_busy: got %b want 1", hold_a);
        end
        tick();
        tick();
        nvec++;
        if ({bus_a.if_ack, bus_a.if_rdata} !== {1'b1, 32'h2801000a}) begin
            nerr++; $display("FAIL fetch_ack: got ack=%b rdata=%h want 1 2801000a", bus_a.if_ack, bus_a.if_rdata);
        end
        tick();
        nvec++;
        if (bus_a.if_ack !== 1'b0) begin
            nerr++; $display("FAIL fetch_ack_pulse: got %b want 0", bus_a.if_ack);
        end
    endtask

    task automatic test_simultaneous();
        owner_t exp_seq [3];
        int     exp_g   [3];
        exp_seq = '{OWN_LD, OWN_DS, OWN_IF};
        exp_g   = '{1, 4, 7};
        start();
        bus_a.ld_req = 1'b1; bus_a.ld_we = 1'b1; bus_a.ld_addr = 10'd5; bus_a.ld_wdata = 32'h00222000;
        bus_a.ds_req = 1'b1; bus_a.ds_we = 1'b0; bus_a.ds_addr = 10'd5; bus_a.ds_wdata = 32'h0;
        bus_a.if_req = 1'b1; bus_a.if_addr = 10'd0;
        repeat (12) tick();
        bus_a.ld_we = 1'b0;
        nvec++;
        if (n_gnt !== 3) begin
            nerr++; $display("FAIL sim_grant_count: got %0d want 3", n_gnt);
        end
        for (int i = 0; i < 3; i++) begin
            nvec++;
            if (seq[i] !== exp_seq[i] || gnt_at[exp_seq[i]] !== exp_g[i]) begin
                nerr++; $display("FAIL sim_order[%0d]: got %s at %0d want %s at %0d",
                    i, seq[i].name(), gnt_at[exp_seq[i]], exp_seq[i].name(), exp_g[i]);
            end
            nvec++;
            if (ack_at[exp_seq[i]] !== exp_g[i] + 2) begin
                nerr++; $display("FAIL sim_ack[%0d]: got %0d want %0d", i, ack_at[exp_seq[i]], exp_g[i] + 2);
            end
        end
        nvec++;
        if ({ds_seen, if_seen} !== {32'h00222000, 32'h2801000a}) begin
            nerr++; $display("FAIL sim_rdata: got ds=%h if=%h want 00222000 2801000a", ds_seen, if_seen);
        end
    endtask

    task automatic test_halted();
        start();
        halted = 1'b1;
        bus_a.if_req = 1'b1; bus_a.if_addr = 10'd0;
        bus_a.ds_req = 1'b1; bus_a.ds_we = 1'b1; bus_a.ds_addr = 10'd7; bus_a.ds_wdata = 32'h00000777;
        repeat (20) tick();
        nvec++;
        if (gnt_at[OWN_IF] !== -1) begin
            nerr++; $display("FAIL halt_no_fetch: got if_gnt at %0d want none", gnt_at[OWN_IF]);
        end
        nvec++;
        if (gnt_at[OWN_DS] !== 1 || ack_at[OWN_DS] !== 3 || memwe_cnt !== 1) begin
            nerr++; $display("FAIL halt_store: got gnt=%0d ack=%0d we_pulses=%0d want 1 3 1",
                gnt_at[OWN_DS], ack_at[OWN_DS], memwe_cnt);
        end
        nvec++;
        if ({hold_a, bus_a.ds_rdata} !== {1'b0, 32'h00222000}) begin
            nerr++; $display("FAIL halt_hold_rdata: got hold=%b ds_rdata=%h want 0 00222000", hold_a, bus_a.ds_rdata);
        end
        bus_a.ds_we = 1'b0;
        halted = 1'b0;
        start();
        repeat (4) tick();
        nvec++;
        if (gnt_at[OWN_IF] !== 1 || ack_at[OWN_IF] !== 3) begin
            nerr++; $display("FAIL unhalt_fetch: got gnt=%0d ack=%0d want 1 3", gnt_at[OWN_IF], ack_at[OWN_IF]);
        end
    endtask

    task automatic test_reset_midwait();
        start();
        bus_a.if_req = 1'b1; bus_a.if_addr = 10'd0;
        tick();
        nvec++;
        if ({bus_a.if_gnt, busy_a} !== 2'b11) begin
            nerr++; $display("FAIL midwait_setup: got gnt/busy=%b want 11", {bus_a.if_gnt, busy_a});
        end
        #2 rst_n = 1'b0;
        #1;
        nvec++;
        if ({bus_a.if_gnt, bus_a.mem_en, busy_a, hold_a, bus_a.if_rdata} !== '0) begin
            nerr++; $display("FAIL midwait_reset: got gnt=%b en=%b busy=%b hold=%b rdata=%h want all 0",
                bus_a.if_gnt, bus_a.mem_en, busy_a, hold_a, bus_a.if_rdata);
        end
        #1 rst_n = 1'b1;
        repeat (6) tick();
        nvec++;
        if (ack_at[OWN_IF] !== -1) begin
            nerr++; $display("FAIL midwait_no_ack: got if_ack at %0d want none", ack_at[OWN_IF]);
        end
        start();
        bus_a.if_req = 1'b1;
        repeat (4) tick();
        nvec++;
        if (gnt_at[OWN_IF] !== 1 || ack_at[OWN_IF] !== 3 || if_seen !== 32'h2801000a) begin
            nerr++; $display("FAIL midwait_refetch: got gnt=%0d ack=%0d rdata=%h want 1 3 2801000a",
                gnt_at[OWN_IF], ack_at[OWN_IF], if_seen);
        end
    endtask

    task automatic test_starvation();
        owner_t exp_seq [6];
        exp_seq = '{OWN_DS, OWN_DS, OWN_DS, OWN_DS, OWN_IF, OWN_DS};
        start();
        sticky = 1'b1;
        bus_a.ds_req = 1'b1; bus_a.ds_we = 1'b0; bus_a.ds_addr = 10'd5;
        bus_a.if_req = 1'b1; bus_a.if_addr = 10'd0;
        repeat (18) tick();
        bus_a.ds_req = 1'b0;
        bus_a.if_req = 1'b0;
        sticky = 1'b0;
        repeat (3) tick();
        nvec++;
        if (n_gnt !== 6) begin
            nerr++; $display("FAIL starve_count: got %0d grants want 6", n_gnt);
        end
        for (int i = 0; i < 6; i++) begin
            nvec++;
            if (seq[i] !== exp_seq[i]) begin
                nerr++; $display("FAIL starve_order[%0d]: got %s want %s", i, seq[i].name(), exp_seq[i].name());
            end
        end
        nvec++;
        if (ds_seen !== 32'h00222000) begin
            nerr++; $display("FAIL starve_rdata: got %h want 00222000", ds_seen);
        end
    endtask

    task automatic test_lat3();
        int   g, a, bad_addr, bad_en;
        bit   seen_ack;
        bus_b.ld_req = 1'b1; bus_b.ld_we = 1'b1; bus_b.ld_addr = 10'd9; bus_b.ld_wdata = 32'h12345678;
        seen_ack = 1'b0;
        for (int k = 1; k <= 20 && !seen_ack; k++) begin
            @(posedge clk); #1;
            if (bus_b.ld_gnt) bus_b.ld_req = 1'b0;
            if (bus_b.ld_ack) seen_ack = 1'b1;
        end
        nvec++;
        if (!seen_ack) begin
            nerr++; $display("FAIL lat3_write_timeout: got no ld_ack within 20 cycles want ack");
        end
        bus_b.ld_req = 1'b0; bus_b.ld_we = 1'b0;
        g = 0; a = 0; bad_addr = 0; bad_en = 0;
        bus_b.ds_req = 1'b1; bus_b.ds_we = 1'b0; bus_b.ds_addr = 10'd9;
        for (int k = 1; k <= 20 && a == 0; k++) begin
            @(posedge clk); #1;
            if (bus_b.ds_gnt) begin g = k; bus_b.ds_req = 1'b0; end
            if (g != 0 && bus_b.mem_addr !== 10'd9) bad_addr++;
            if (g != 0 && k != g && bus_b.mem_en) bad_en++;
            if (bus_b.ds_ack) a = k;
        end
        nvec++;
        if (a == 0 || g == 0 || a - g != 4) begin
            nerr++; $display("FAIL lat3_latency: got gnt=%0d ack=%0d want ack-gnt=4", g, a);
        end
        nvec++;
        if (bad_addr !== 0 || bad_en !== 0) begin
            nerr++; $display("FAIL lat3_stable: got addr_changes=%0d extra_en=%0d want 0 0", bad_addr, bad_en);
        end
        nvec++;
        if ({bus_b.ds_rdata, busy_b} !== {32'h12345678, 1'b0}) begin
            nerr++; $display("FAIL lat3_rdata: got rdata=%h busy=%b want 12345678 0", bus_b.ds_rdata, busy_b);
        end
    endtask

    initial begin
        sticky = 1'b0;
        bus_a.ld_req = 1'b0; bus_a.ld_we = 1'b0; bus_a.ld_addr = '0; bus_a.ld_wdata = '0;
        bus_a.ds_req = 1'b0; bus_a.ds_we = 1'b0; bus_a.ds_addr = '0; bus_a.ds_wdata = '0;
        bus_a.if_req = 1'b0; bus_a.if_addr = '0;
        bus_b.ld_req = 1'b0; bus_b.ld_we = 1'b0; bus_b.ld_addr = '0; bus_b.ld_wdata = '0;
        bus_b.ds_req = 1'b0; bus_b.ds_we = 1'b0; bus_b.ds_addr = '0; bus_b.ds_wdata = '0;
        bus_b.if_req = 1'b0; bus_b.if_addr = '0;
        test_reset();
        test_loader();
        test_single_fetch();
        test_simultaneous();
        test_halted();
        test_reset_midwait();
        test_starvation();
        test_lat3();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
